// File: rtl/serial_adder.sv
// serial_adder: bit-serial ripple adder, one operand bit per clock.
//
// Ports:
//   clk    - clock; all state updates on the rising edge
//   rst_n  - asynchronous active-low reset; aborts any operation in progress
//   start  - begin an addition; accepted only in IDLE or DONE
//   a, b   - WIDTH-bit operands, captured on the accepting edge
//   cin    - carry-in, captured on the accepting edge
//   busy   - high while bits are being shifted (SHIFT state)
//   done   - one-cycle pulse; sum/cout hold a new result
//   sum    - registered a + b + cin modulo 2^WIDTH
//   cout   - registered carry-out of the addition
//
// Timing: start accepted at edge k -> busy for WIDTH cycles, done high in
// the cycle after edge k+WIDTH. A start seen in DONE chains the next
// operation without an idle cycle.
module serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned      CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state;
    logic [WIDTH-1:0]   sh_a;
    logic [WIDTH-1:0]   sh_b;
    logic [WIDTH-1:0]   sh_s;
    logic               carry;
    logic [CNT_W-1:0]   cnt;

    logic               s_bit_c;
    logic               c_bit_c;
    logic [WIDTH-1:0]   sh_s_next_c;

    // Full adder on the current LSBs and the running carry.
    assign s_bit_c     = sh_a[0] ^ sh_b[0] ^ carry;
    assign c_bit_c     = (sh_a[0] & sh_b[0]) | (sh_a[0] & carry) | (sh_b[0] & carry);

    // Sum bits enter at the MSB so that after WIDTH shifts bit 0 sits at the LSB.
    assign sh_s_next_c = {s_bit_c, sh_s[WIDTH-1:1]};

    // Control FSM and datapath; busy/done are registered alongside the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            sh_a  <= '0;
            sh_b  <= '0;
            sh_s  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        sh_a  <= a;
                        sh_b  <= b;
                        sh_s  <= '0;
                        carry <= cin;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= SHIFT;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end

                SHIFT: begin
                    // start is deliberately ignored here.
                    sh_a  <= {1'b0, sh_a[WIDTH-1:1]};
                    sh_b  <= {1'b0, sh_b[WIDTH-1:1]};
                    sh_s  <= sh_s_next_c;
                    carry <= c_bit_c;
                    cnt   <= cnt + CNT_W'(1);
                    if (cnt == LAST_BIT) begin
                        // Publish only the completed result; sum never shows partial bits.
                        sum   <= sh_s_next_c;
                        cout  <= c_bit_c;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end

                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed-vector bench for serial_adder (WIDTH = 8).
module tb_serial_adder;

    localparam int unsigned WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    int vec_cnt  = 0;
    int miss_cnt = 0;

    serial_adder #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // One addition from IDLE. Operands are scrambled after the accepting edge;
    // with glitch set, start is re-pulsed mid-SHIFT with different operands.
    task automatic run_add(input string tag, input logic [7:0] va, input logic [7:0] vb,
                           input logic vc, input logic [7:0] exp_s, input logic exp_c,
                           input bit glitch);
        logic [7:0] prev;
        int busy_n;
        int done_n;
        int done_at;
        logic [7:0] s_at4;
        busy_n  = 0;
        done_n  = 0;
        done_at = -1;
        s_at4   = '0;
        @(negedge clk);
        start = 1'b1; a = va; b = vb; cin = vc;
        prev = sum;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (busy) busy_n++;
            if (done) begin
                done_n++;
                if (done_at < 0) done_at = i;
            end
            if (i == 4) s_at4 = sum;
            if (i == 1) begin
                start = 1'b0; a = ~va; b = ~vb; cin = ~vc;
            end
            if (glitch && i == 3) begin
                start = 1'b1; a = 8'hFF; b = 8'hFF; cin = 1'b1;
            end
            if (i == 4) start = 1'b0;
        end
        check({tag, " busy_cycles"}, 32'(busy_n), 32'd8);
        check({tag, " done_edge"}, 32'(done_at), 32'd9);
        check({tag, " done_pulses"}, 32'(done_n), 32'd1);
        check({tag, " sum_held"}, 32'(s_at4), 32'(prev));
        check({tag, " sum"}, 32'(sum), 32'(exp_s));
        check({tag, " cout"}, 32'(cout), 32'(exp_c));
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        cin   = 1'b0;
        repeat (2) @(negedge clk);
        check("rst busy", 32'(busy), 32'd0);
        check("rst done", 32'(done), 32'd0);
        check("rst sum",  32'(sum),  32'd0);
        check("rst cout", 32'(cout), 32'd0);
        rst_n = 1'b1;

        run_add("00+00",    8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
        run_add("FF+01",    8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        run_add("7F+01",    8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b0);
        run_add("12+34 ign",8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b1);
        run_add("A5+5A+1",  8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 1'b0);

        // Back-to-back: start held high across DONE.
        @(negedge clk);
        start = 1'b1; a = 8'h10; b = 8'h20; cin = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (i == 1) start = 1'b0;
            if (i == 8) begin
                start = 1'b1; a = 8'h01; b = 8'h01; cin = 1'b0;
            end
            if (i == 9) begin
                check("b2b first done", 32'(done), 32'd1);
                check("b2b first sum",  32'(sum),  32'h30);
                check("b2b first cout", 32'(cout), 32'd0);
            end
            if (i == 10) begin
                start = 1'b0; a = 8'hEE; b = 8'hDD;
                check("b2b restart busy", 32'(busy), 32'd1);
                check("b2b restart done", 32'(done), 32'd0);
            end
            if (i == 14) check("b2b sum held", 32'(sum), 32'h30);
            if (i == 17) check("b2b early done", 32'(done), 32'd0);
            if (i == 18) begin
                check("b2b second done", 32'(done), 32'd1);
                check("b2b second sum",  32'(sum),  32'h02);
                check("b2b second cout", 32'(cout), 32'd0);
            end
        end

        // Asynchronous reset in the 4th SHIFT cycle.
        @(negedge clk);
        start = 1'b1; a = 8'h55; b = 8'h11; cin = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            if (i == 1) start = 1'b0;
        end
        check("pre-rst busy", 32'(busy), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("arst busy", 32'(busy), 32'd0);
        check("arst done", 32'(done), 32'd0);
        check("arst sum",  32'(sum),  32'd0);
        check("arst cout", 32'(cout), 32'd0);
        #1 rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("post-rst idle busy", 32'(busy), 32'd0);
        check("post-rst idle done", 32'(done), 32'd0);

        run_add("03+04",    8'h03, 8'h04, 1'b0, 8'h07, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
